// File: rtl/edid_i2c_pkg.sv
// Shared types and default constants for the EDID EEPROM emulator.
//   i2c_state_t          : slave protocol state
//   SLV_ADDR_DEFAULT     : 7-bit device address (24Cxx EDID slot)
//   FILT_LEN_DEFAULT     : samples needed before a filtered line changes
//   HOLD_CYC_DEFAULT     : SDA hold time after SCL falls, in clk_50 cycles
package edid_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK,
    WR_OFFSET,
    WR_DATA,
    RD_DATA,
    RD_ACK,
    SKIP
  } i2c_state_t;

  localparam logic [6:0]  SLV_ADDR_DEFAULT = 7'h50;
  localparam int unsigned FILT_LEN_DEFAULT = 4;
  localparam int unsigned HOLD_CYC_DEFAULT = 8;

endpackage

// File: rtl/edid_i2c_slave_line_filter.sv
// Two-flop synchroniser plus glitch filter for one I2C line.
//   clk_50, reset_n : clock, async active-low reset
//   line_raw        : raw pin level
//   line_f          : filtered level (changes after FILT_LEN equal samples)
//   rise, fall      : one-cycle strobes, high in the cycle line_f changes
module i2c_line_filter
  import edid_i2c_pkg::*;
#(
  parameter int unsigned FILT_LEN = FILT_LEN_DEFAULT
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic line_raw,
  output logic line_f,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync   <= '1;
      line_f <= 1'b1;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync <= {sync[0], line_raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == line_f) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        line_f <= sync[1];
        rise   <= sync[1];
        fall   <= ~sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/edid_i2c_slave.sv
// 256-byte EDID EEPROM emulator: 24Cxx-style I2C slave.
//   clk_50, reset_n : 50 MHz clock, async active-low reset
//   scl_i, sda_i    : raw bus levels
//   sda_oe          : 1 = pull SDA low
//   wp              : write protect, data bytes NACKed and not written
//   busy            : address-matched transaction in progress (until STOP)
//   edid_updated    : one-cycle pulse at a STOP after >=1 data byte written
module edid_i2c_slave
  import edid_i2c_pkg::*;
#(
  parameter logic [6:0]  SLV_ADDR = SLV_ADDR_DEFAULT,
  parameter int unsigned FILT_LEN = FILT_LEN_DEFAULT,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEFAULT
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe,
  input  logic wp,
  output logic busy,
  output logic edid_updated
);

  localparam int unsigned HW = $clog2(HOLD_CYC + 1);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;
  logic start_cond, stop_cond;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk_50(clk_50), .reset_n(reset_n), .line_raw(scl_i),
    .line_f(scl_f), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk_50(clk_50), .reset_n(reset_n), .line_raw(sda_i),
    .line_f(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_cond = sda_fall & scl_f;
  assign stop_cond  = sda_rise & scl_f;

  i2c_state_t    state_q, state_d, ret_q, ret_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d, offset_q, offset_d, tx_q, tx_d;
  logic          ack_drv_q, ack_drv_d, ack_rise_q, ack_rise_d;
  logic          busy_d, wrote_q, wrote_d, upd_d;
  logic          ram_we, drive;
  logic [7:0]    shift_byte, ram_q;
  logic [7:0]    mem [256];
  logic [HW-1:0] hold_cnt;

  // Single-port RAM addressed by offset; read every cycle so ram_q always
  // holds the byte at the current offset well before it is shifted out.
  always_ff @(posedge clk_50) begin
    if (ram_we) mem[offset_q] <= shift_byte;
    ram_q <= mem[offset_q];
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    offset_d   = offset_q;
    tx_d       = tx_q;
    ack_drv_d  = ack_drv_q;
    ack_rise_d = ack_rise_q;
    busy_d     = busy;
    wrote_d    = wrote_q;
    upd_d      = 1'b0;
    ram_we     = 1'b0;
    shift_byte = {shreg_q[6:0], sda_f};
    if (stop_cond) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      wrote_d = 1'b0;
      upd_d   = wrote_q;
    end else if (start_cond) begin
      state_d    = ADDR;
      bit_cnt_d  = '0;
      ack_rise_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, SKIP: ;
        ADDR, WR_OFFSET, WR_DATA: begin
          if (scl_rise) begin
            shreg_d   = shift_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d    = ACK;
              ack_drv_d  = 1'b1;
              ack_rise_d = 1'b0;
              ret_d      = WR_DATA;
              case (state_q)
                ADDR: begin
                  if (shift_byte[7:1] == SLV_ADDR) begin
                    busy_d = 1'b1;
                    ret_d  = shift_byte[0] ? RD_DATA : WR_OFFSET;
                  end else begin
                    state_d = SKIP;
                  end
                end
                WR_OFFSET: offset_d = shift_byte;
                default: begin
                  if (wp) begin
                    ack_drv_d = 1'b0;
                  end else begin
                    ram_we   = 1'b1;
                    offset_d = offset_q + 8'd1;
                    wrote_d  = 1'b1;
                  end
                end
              endcase
            end
          end
        end
        // Ninth clock: wait for its rise, then leave on its fall so the
        // following drive change lands HOLD_CYC after that fall.
        ACK: begin
          if (scl_rise) begin
            ack_rise_d = 1'b1;
          end else if (scl_fall && ack_rise_q) begin
            state_d   = ret_q;
            bit_cnt_d = '0;
            if (ret_q == RD_DATA) tx_d = ram_q;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = RD_ACK;
          end
        end
        // Offset advances after every byte delivered, ACKed or not, so a
        // later current-address read resumes after the last byte sent.
        RD_ACK: begin
          if (scl_rise) begin
            offset_d = offset_q + 8'd1;
            if (!sda_f) begin
              state_d    = ACK;
              ack_rise_d = 1'b1;
              ack_drv_d  = 1'b0;
              ret_d      = RD_DATA;
            end else begin
              state_d = SKIP;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    drive = 1'b0;
    case (state_q)
      ACK:     drive = ack_drv_q;
      RD_DATA: drive = ~tx_q[3'd7 - bit_cnt_q];
      default: drive = 1'b0;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ret_q        <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      offset_q     <= '0;
      tx_q         <= '0;
      ack_drv_q    <= 1'b0;
      ack_rise_q   <= 1'b0;
      busy         <= 1'b0;
      wrote_q      <= 1'b0;
      edid_updated <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      offset_q     <= offset_d;
      tx_q         <= tx_d;
      ack_drv_q    <= ack_drv_d;
      ack_rise_q   <= ack_rise_d;
      busy         <= busy_d;
      wrote_q      <= wrote_d;
      edid_updated <= upd_d;
    end
  end

  // sda_oe only moves HOLD_CYC cycles after SCL falls, sampling the drive
  // value of whatever state the FSM has reached by then.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      sda_oe   <= 1'b0;
      hold_cnt <= '0;
    end else if (start_cond || stop_cond) begin
      sda_oe   <= 1'b0;
      hold_cnt <= '0;
    end else if (scl_fall) begin
      hold_cnt <= HW'(HOLD_CYC);
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HW'(1);
      if (hold_cnt == HW'(1)) sda_oe <= drive;
    end
  end

endmodule

// File: tb/tb_edid_i2c_slave.sv
// Directed bench for edid_i2c_slave: behavioural I2C master on an
// open-drain SDA line, all checks through check_eq.
module tb_edid_i2c_slave;

  localparam int Q = 20;

  logic clk_50 = 1'b0;
  logic reset_n = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic wp = 1'b0;
  logic glitch_en = 1'b0;
  logic sda_oe, busy, edid_updated, sda_line;

  int tests_run = 0;
  int tests_failed = 0;
  int upd_cnt = 0;

  assign sda_line = sda_m & ~sda_oe;

  edid_i2c_slave #(.SLV_ADDR(7'h50), .FILT_LEN(4), .HOLD_CYC(8)) dut (
    .clk_50(clk_50), .reset_n(reset_n), .scl_i(scl), .sda_i(sda_line),
    .sda_oe(sda_oe), .wp(wp), .busy(busy), .edid_updated(edid_updated)
  );

  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) if (edid_updated) upd_cnt++;

  initial begin
    repeat (150000) @(posedge clk_50);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; tick(Q); scl = 1'b1; tick(Q);
    if (glitch_en) begin
      sda_m = ~b; tick(2); sda_m = b; tick(Q - 2);
    end else begin
      tick(Q);
    end
    scl = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q); scl = 1'b1; tick(Q);
    b = sda_line; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    acked = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~ack);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; tick(Q); scl = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; tick(Q); scl = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q); tick(Q);
  endtask

  task automatic write_txn(input string tag, input logic [7:0] off,
                           input logic [7:0] d [4], input int n, input int exp_upd);
    logic a;
    i2c_start;
    send_byte(8'hA0, a); check_eq({tag, "_addr_ack"}, 32'(a), 1);
    send_byte(off, a);   check_eq({tag, "_off_ack"}, 32'(a), 1);
    for (int i = 0; i < n; i++) begin
      send_byte(d[i], a);
      check_eq($sformatf("%s_data_ack%0d", tag, i), 32'(a), 1);
    end
    check_eq({tag, "_busy"}, 32'(busy), 1);
    i2c_stop;
    check_eq({tag, "_busy_after"}, 32'(busy), 0);
    check_eq({tag, "_upd_cnt"}, upd_cnt, exp_upd);
  endtask

  task automatic read_txn(input string tag, input logic [7:0] off,
                          input int n, input logic [7:0] exp [4]);
    logic a;
    logic [7:0] b;
    i2c_start;
    send_byte(8'hA0, a); check_eq({tag, "_addr_ack"}, 32'(a), 1);
    send_byte(off, a);   check_eq({tag, "_off_ack"}, 32'(a), 1);
    i2c_start;
    send_byte(8'hA1, a); check_eq({tag, "_raddr_ack"}, 32'(a), 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(b, i != n - 1);
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp[i]));
    end
    i2c_stop;
  endtask

  initial begin
    logic a;
    logic [7:0] b;

    tick(5);
    check_eq("rst_sda_oe", 32'(sda_oe), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_upd", 32'(edid_updated), 0);
    reset_n = 1'b1;
    tick(10);

    write_txn("wr0", 8'h00, '{8'h00, 8'hFF, 8'hFF, 8'hFF}, 4, 1);
    write_txn("wr4", 8'h04, '{8'h5A, 8'h00, 8'h00, 8'h00}, 1, 2);
    write_txn("wr10", 8'h10, '{8'h3C, 8'h00, 8'h00, 8'h00}, 1, 3);

    read_txn("rr2", 8'h02, 2, '{8'hFF, 8'hFF, 8'h00, 8'h00});
    check_eq("rr2_upd_cnt", upd_cnt, 3);

    // Current-address read: offset must have advanced to 0x04
    i2c_start;
    send_byte(8'hA1, a); check_eq("cur_addr_ack", 32'(a), 1);
    recv_byte(b, 1'b0);  check_eq("cur_byte", 32'(b), 'h5A);
    i2c_stop;

    // Wrong address 0x51
    i2c_start;
    send_byte(8'hA2, a); check_eq("a51_nack", 32'(a), 0);
    check_eq("a51_busy", 32'(busy), 0);
    send_byte(8'h00, a); check_eq("a51_off_nack", 32'(a), 0);
    send_byte(8'h77, a); check_eq("a51_data_nack", 32'(a), 0);
    i2c_stop;
    check_eq("a51_busy_after", 32'(busy), 0);
    check_eq("a51_upd_cnt", upd_cnt, 3);

    read_txn("rd0", 8'h00, 4, '{8'h00, 8'hFF, 8'hFF, 8'hFF});

    // Write protect
    wp = 1'b1;
    i2c_start;
    send_byte(8'hA0, a); check_eq("wp_addr_ack", 32'(a), 1);
    send_byte(8'h10, a); check_eq("wp_off_ack", 32'(a), 1);
    send_byte(8'hAA, a); check_eq("wp_data_nack", 32'(a), 0);
    i2c_stop;
    wp = 1'b0;
    check_eq("wp_upd_cnt", upd_cnt, 3);
    read_txn("rd10", 8'h10, 1, '{8'h3C, 8'h00, 8'h00, 8'h00});

    // Offset wrap on write and sequential read
    write_txn("wrFE", 8'hFE, '{8'h11, 8'h22, 8'h33, 8'h00}, 3, 4);
    read_txn("rdFE", 8'hFE, 3, '{8'h11, 8'h22, 8'h33, 8'h00});

    // 2-cycle SDA glitches while SCL high during every data bit
    i2c_start;
    send_byte(8'hA0, a); check_eq("gl_addr_ack", 32'(a), 1);
    send_byte(8'h20, a); check_eq("gl_off_ack", 32'(a), 1);
    glitch_en = 1'b1;
    send_byte(8'h4B, a);
    glitch_en = 1'b0;
    check_eq("gl_data_ack", 32'(a), 1);
    check_eq("gl_busy", 32'(busy), 1);
    i2c_stop;
    check_eq("gl_upd_cnt", upd_cnt, 5);

    // Reset while slave drives the first (0) bit of 0x4B
    i2c_start;
    send_byte(8'hA0, a); check_eq("rs_addr_ack", 32'(a), 1);
    send_byte(8'h20, a); check_eq("rs_off_ack", 32'(a), 1);
    i2c_start;
    send_byte(8'hA1, a); check_eq("rs_raddr_ack", 32'(a), 1);
    sda_m = 1'b1; tick(Q); scl = 1'b1; tick(Q);
    check_eq("rs_drive_bit7", 32'(sda_oe), 1);
    reset_n = 1'b0;
    #1;
    check_eq("rs_async_release", 32'(sda_oe), 0);
    check_eq("rs_busy", 32'(busy), 0);
    tick(4);
    reset_n = 1'b1;
    tick(Q);
    read_txn("rd20", 8'h20, 1, '{8'h4B, 8'h00, 8'h00, 8'h00});
    check_eq("final_upd_cnt", upd_cnt, 5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/edid_i2c_slave.md
Name: edid_i2c_slave

Overview:
- Hardware EDID EEPROM emulator: a 256-byte I2C slave at 7-bit address 0x50.
- Sits directly downstream of the Nios system's bit-banged rx EDID I2C master lines (SCL output, SDA inout). Firmware writes the EDID image through it; the HDMI source reads it back over the same bus.
- Synchronises and filters SCL/SDA and detects START/repeated-START/STOP. Implements the 24Cxx byte-write/sequential-read protocol, with offset auto-increment.

Parameters:
- SLV_ADDR, 7'h50, 7-bit device address matched.
- FILT_LEN, 4, consecutive equal samples required before a filtered SCL/SDA level changes.
- HOLD_CYC, 8, clk_50 cycles after filtered SCL falls before sda_oe may change (SDA hold time).

Ports:
- clk_50  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- scl_i  in  1  raw SCL pin level.
- sda_i  in  1  raw SDA pin level.
- sda_oe  out  1  1 = pull SDA low (open-drain); pad ties output data to 0.
- wp  in  1  write protect; 1 = writes NACKed after the offset byte.
- busy  out  1  high from an address-matched START until STOP.
- edid_updated  out  1  one-cycle pulse at STOP ending a transaction that wrote ≥1 data byte.

Behaviour:
- Reset: clock and reset are decided — a single clock clk_50; reset_n is asynchronous and active-low. Reset values: sda_oe=0, busy=0, edid_updated=0; state=IDLE; offset=0; filters preset to 1. RAM contents are not reset.
- Input path:
  - 2-flop synchroniser, then a FILT_LEN-sample filter on each line.
  - Edge detection uses the filtered signals only.
- Bus conditions (filtered signals):
  - START = SDA falls while SCL high. It is honoured in any state, aborts the current byte and goes to ADDR; bit counter = 0.
  - STOP = SDA rises while SCL high. It goes to IDLE from any state, releases sda_oe, clears busy, and pulses edid_updated if any data byte was written.
- Sampling: SDA is sampled on filtered SCL rising edges, MSB first, 3-bit counter.
- Driving: sda_oe changes only HOLD_CYC cycles after a filtered SCL falling edge. It is never changed while SCL is high.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - Addr match + R/W=0 → ACK → WR_OFFSET.
    - Addr match + R/W=1 → ACK → RD_DATA.
    - Mismatch → SKIP (no ACK, sda_oe stays 0 until START/STOP).
  - ACK: drive sda_oe=1 for exactly one SCL high period; release at the following SCL fall + HOLD_CYC.
  - WR_OFFSET: shift 8 bits into offset; ACK always → WR_DATA.
  - WR_DATA, on the 8th bit:
    - wp=0: write RAM[offset], offset++, ACK.
    - wp=1: NACK, no write, no increment.
    - Additional bytes continue sequentially.
  - RD_DATA:
    - Load RAM[offset] when entering the byte; drive the inverse of each bit (sda_oe = ~bit).
    - After 8 bits, release SDA and sample the master's ACK on SCL rise.
    - ACK (SDA=0): offset++ → next RD_DATA.
    - NACK: → SKIP until STOP/START.
- Offset arithmetic: 8-bit, wraps 0xFF→0x00 for both writes and reads.
- Repeated START after WR_OFFSET (random read): the offset is retained; the read starts at that offset.
- RAM: synchronous 256x8, one read/write port. Reads are issued at least HOLD_CYC cycles before the first bit is needed.
- wp sampled at the 8th data bit rising edge.
- Reset mid-transaction: immediate release of SDA; RAM unchanged.

Decomposition:
- Package edid_i2c_pkg:
  - State enum: IDLE, ADDR, ACK, WR_OFFSET, WR_DATA, RD_DATA, RD_ACK, SKIP.
  - Default constants SLV_ADDR and FILT_LEN.
- Sub-module i2c_line_filter (sync + glitch filter + rise/fall strobes), instantiated for SCL and for SDA.

Test Plan:
- Write 0x00,[0x00,0xFF,0xFF,0xFF] to addr 0x50, then STOP → four ACKs after data, RAM[0..3]={00,FF,FF,FF}, edid_updated pulses once, busy low after STOP.
- Random read: write offset 0x02, repeated START, read addr 0xA1, 2 bytes ACK/NACK → bytes 0xFF,0xFF on SDA; offset ends at 0x04.
- Address 0x51 write → no ACK (SDA high on 9th clock), busy stays 0, RAM unchanged.
- wp=1, write offset 0x10 data 0xAA → offset ACKed, data NACKed, RAM[0x10] unchanged, no edid_updated.
- Sequential read from offset 0xFE for 3 bytes → RAM[FE],RAM[FF],RAM[00] returned (wrap).
- 2-cycle SDA glitch while SCL high, plus reset_n asserted mid-read → no false START/STOP; on reset sda_oe=0 immediately, next transaction works normally.
